rr_arb_mux: RTL and testbench

Parametrised N-channel arbitrated multiplexer with a registered, valid/ready-handshaked output. It generalises the combinational 32-bit selectors in the datapath in three ways:
- configurable width and channel count;
- round-robin or fixed-priority arbitration replaces an external select;
- a single output register gives backpressure.

Typical uses are sharing one memory/bus port between instruction fetch, data access and other requesters, and funnelling write-back sources.

---
 rtl/rr_arb_mux_if.sv | 25 ++
 rtl/rr_arb_mux.sv | 105 ++++++++++
 tb/tb_rr_arb_mux.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N request channels in, one registered word out.
// The arbiter connects through the slave modport; the producer/consumer side uses master.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer (round-robin or fixed priority) feeding a single
// valid/ready output register.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] ch_data [N];
  logic [N-1:0]     ready_vec;
  logic [WIDTH-1:0] sel_data;

  logic [SELW-1:0]  search_base;
  logic [SELW-1:0]  grant_sel;
  logic             grant_found;
  logic             any_valid;
  logic             load_en;
  logic             accept;

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [SELW-1:0]  out_sel_reg,   out_sel_next;
  logic [SELW-1:0]  ptr_reg,       ptr_next;

  // Index base+k modulo N; N need not be a power of two, so wrap explicitly.
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]   = bus.in_data[gi*WIDTH +: WIDTH];
      assign ready_vec[gi] = accept && (grant_sel == SELW'(gi));
    end
  endgenerate

  assign any_valid = |bus.in_valid;
  assign load_en   = !out_valid_reg || bus.out_ready;
  // Reset wins over any handshake, so nothing is offered as accepted during it.
  assign accept    = load_en && any_valid && !rst;

  always_comb begin : grant_search
    search_base = (MODE != 0) ? '0 : ptr_reg;
    grant_sel   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!grant_found && bus.in_valid[wrap_idx(search_base, k)]) begin
        grant_found = 1'b1;
        grant_sel   = wrap_idx(search_base, k);
      end
    end
  end

  always_comb begin : data_mux
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_sel == SELW'(i)) sel_data = ch_data[i];
    end
  end

  always_comb begin : next_state
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    ptr_next       = ptr_reg;
    if (accept) begin
      out_valid_next = 1'b1;
      out_data_next  = sel_data;
      out_sel_next   = grant_sel;
      if (MODE == 0) begin
        ptr_next = (grant_sel == SELW'(N - 1)) ? '0 : grant_sel + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (RR N=4, RR N=3, fixed N=4) checked against
// an arbitration model and a queue of expected output words.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(32), .N(4)) if4 ();
  rr_arb_mux_if #(.WIDTH(32), .N(3)) if3 ();
  rr_arb_mux_if #(.WIDTH(32), .N(4)) ifp ();

  rr_arb_mux #(.WIDTH(32), .N(4), .MODE(0)) u_rr4 (.clk(clk), .rst(rst), .bus(if4.slave));
  rr_arb_mux #(.WIDTH(32), .N(3), .MODE(0)) u_rr3 (.clk(clk), .rst(rst), .bus(if3.slave));
  rr_arb_mux #(.WIDTH(32), .N(4), .MODE(1)) u_fp  (.clk(clk), .rst(rst), .bus(ifp.slave));

  typedef struct packed {
    logic [1:0]  dut;
    logic [4:0]  sel;
    logic [31:0] data;
  } sb_t;

  sb_t q[$];
  int  nvec = 0;
  int  nerr = 0;
  int  delivered = 0;
  int  saved;
  int  mptr[3] = '{0, 0, 0};
  int  nch[3]  = '{4, 3, 4};
  int  mode[3] = '{0, 0, 1};
  bit  prev_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int grant(input logic [3:0] v, input int p, input int n, input int md);
    int s;
    s = (md != 0) ? 0 : p;
    for (int k = 0; k < n; k++) begin
      if (v[(s + k) % n]) return (s + k) % n;
    end
    return 0;
  endfunction

  task automatic drive(input int d, input logic [3:0] vld, input logic [127:0] dat,
                       input logic ordy, input logic r);
    if4.in_valid = '0; if4.in_data = '0; if4.out_ready = 1'b1;
    if3.in_valid = '0; if3.in_data = '0; if3.out_ready = 1'b1;
    ifp.in_valid = '0; ifp.in_data = '0; ifp.out_ready = 1'b1;
    rst = r;
    case (d)
      0: begin if4.in_valid = vld; if4.in_data = dat; if4.out_ready = ordy; end
      1: begin if3.in_valid = vld[2:0]; if3.in_data = dat[95:0]; if3.out_ready = ordy; end
      default: begin ifp.in_valid = vld; ifp.in_data = dat; ifp.out_ready = ordy; end
    endcase
  endtask

  task automatic sample(input int d, output logic [3:0] rdy, output logic ov,
                        output logic [31:0] od, output logic [4:0] os);
    case (d)
      0: begin rdy = if4.in_ready; ov = if4.out_valid; od = if4.out_data; os = 5'(if4.out_sel); end
      1: begin rdy = {1'b0, if3.in_ready}; ov = if3.out_valid; od = if3.out_data; os = 5'(if3.out_sel); end
      default: begin rdy = ifp.in_ready; ov = ifp.out_valid; od = ifp.out_data; os = 5'(ifp.out_sel); end
    endcase
  endtask

  // One clock: drive, check outputs and in_ready at negedge, update the model at posedge.
  task automatic step(input int d, input logic [3:0] vld, input logic [127:0] dat,
                      input logic ordy, input logic r);
    logic [3:0]  rdy, exp_rdy, vm;
    logic        ov, exp_ov, le;
    logic [31:0] od;
    logic [4:0]  os;
    int          g;
    sb_t         e;
    drive(d, vld, dat, ordy, r);
    @(negedge clk);
    sample(d, rdy, ov, od, os);
    exp_ov = (q.size() != 0);
    chk("out_valid", 32'(ov), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_data", od, q[0].data);
      chk("out_sel", 32'(os), 32'(q[0].sel));
    end else if (prev_rst) begin
      chk("rst_data", od, 32'h0);
      chk("rst_sel", 32'(os), 32'h0);
    end
    vm      = vld & 4'((1 << nch[d]) - 1);
    le      = !exp_ov || ordy;
    g       = grant(vm, mptr[d], nch[d], mode[d]);
    exp_rdy = (!r && le && vm != 4'b0) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 32'(rdy), 32'(exp_rdy));
    @(posedge clk);
    prev_rst = r;
    if (r) begin
      q.delete();
      mptr = '{0, 0, 0};
    end else begin
      if (exp_ov && ordy) begin
        void'(q.pop_front());
        delivered++;
      end
      if (exp_rdy != 4'b0) begin
        e.dut  = 2'(d);
        e.sel  = 5'(g);
        e.data = dat[g*32 +: 32];
        q.push_back(e);
        if (mode[d] == 0) mptr[d] = (g == nch[d] - 1) ? 0 : g + 1;
      end
    end
    #1;
  endtask

  task automatic drain(input int d);
    repeat (2) step(d, 4'h0, 128'h0, 1'b1, 1'b0);
  endtask

  logic [127:0] rot, bp, cf, d3, fp;

  initial begin
    rot = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    bp  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
    cf  = {32'h4444_4444, 32'hCAFE_F00D, 32'h2222_2222, 32'h5555_5555};
    d3  = {32'h0, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
    fp  = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};

    drive(0, 4'h0, 128'h0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset held with every channel requesting
    step(0, 4'hF, rot, 1'b1, 1'b1);
    step(0, 4'hF, rot, 1'b1, 1'b1);

    // Round-robin rotation, first accept is ch0
    repeat (9) step(0, 4'hF, rot, 1'b1, 1'b0);

    // Backpressure: ch2 delivers DEADBEEF, 5 stall cycles, then ch3 on release
    step(0, 4'b0100, bp, 1'b1, 1'b0);
    repeat (5) step(0, 4'hF, bp, 1'b0, 1'b0);
    step(0, 4'hF, bp, 1'b1, 1'b0);
    step(0, 4'h0, bp, 1'b0, 1'b0);

    // Reset mid-operation discards a stalled CAFEF00D with ptr=3
    step(0, 4'b0100, cf, 1'b1, 1'b0);
    step(0, 4'hF, cf, 1'b0, 1'b0);
    saved = delivered;
    step(0, 4'hF, cf, 1'b1, 1'b1);
    chk("rst_no_deliver", 32'(delivered), 32'(saved));
    step(0, 4'hF, rot, 1'b1, 1'b0);
    drain(0);

    // Random traffic with random backpressure
    repeat (40) step(0, 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 3) != 0), 1'b0);
    drain(0);

    // Non-power-of-two wrap on N=3
    step(1, 4'b0010, d3, 1'b1, 1'b0);
    step(1, 4'b0001, d3, 1'b1, 1'b0);
    step(1, 4'b0110, d3, 1'b1, 1'b0);
    step(1, 4'b0110, d3, 1'b1, 1'b0);
    repeat (20) step(1, 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 3) != 0), 1'b0);
    drain(1);

    // Fixed priority: ch0 starves ch3 until ch0 drops
    repeat (10) step(2, 4'b1001, fp, 1'b1, 1'b0);
    step(2, 4'b1000, fp, 1'b1, 1'b0);
    step(2, 4'b1001, fp, 1'b0, 1'b0);
    drain(2);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
